// File: rtl/best_idx_reorder.sv
// rtl/best_idx_reorder.sv - frame buffer turning blocked-order best indices into raster order
// Optional running output checksum port: REORDER_CHECKSUM_EN.
module best_idx_reorder #(
    parameter int DATA_WIDTH = 11,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_PARTS  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
`ifdef REORDER_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic                  done
);
    localparam int PART_W     = ROW_SIZE / NUM_PARTS;
    localparam int NUM_BLK    = (PART_W + BLOCKING - 1) / BLOCKING;
    localparam int LAST_W     = PART_W - (NUM_BLK - 1) * BLOCKING;
    localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE;
    localparam int ADDRW      = $clog2(NUM_QUERYS);
    localparam int PW         = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
    localparam int BW         = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam int YW         = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int XW         = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

    localparam logic [ADDRW-1:0] STEP_FULL = ADDRW'(ROW_SIZE - BLOCKING + 1);
    localparam logic [ADDRW-1:0] STEP_LAST = ADDRW'(ROW_SIZE - LAST_W + 1);
    localparam logic [ADDRW-1:0] A_BLK     = ADDRW'(BLOCKING);
    localparam logic [ADDRW-1:0] A_PART    = ADDRW'(PART_W);
    localparam logic [ADDRW-1:0] A_LAST    = ADDRW'(NUM_QUERYS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         p;
    logic [BW-1:0]         b;
    logic [YW-1:0]         y;
    logic [XW-1:0]         xi;
    logic [ADDRW-1:0]      wa, blk_base, part_base;
    logic [ADDRW-1:0]      ra, out_cnt;
    logic                  rd_all, rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [NUM_QUERYS];

    logic accept, last_blk, xi_wrap, y_wrap, p_wrap;
    logic load, issue, out_acc, last_out;

    assign in_ready = (state == S_FILL);
    assign busy     = (state != S_IDLE);
    assign accept   = (state == S_FILL) && in_valid;
    assign last_blk = (b == BW'(NUM_BLK - 1));
    assign xi_wrap  = last_blk ? (xi == XW'(LAST_W - 1)) : (xi == XW'(BLOCKING - 1));
    assign y_wrap   = (y == YW'(COL_SIZE - 1));
    assign p_wrap   = (p == PW'(NUM_PARTS - 1));

    // Read stage holds one word so a stalled output never drops an issued read.
    assign load     = rd_vld && (!out_valid || out_ready);
    assign issue    = (state == S_DRAIN) && !rd_all && (!rd_vld || load);
    assign out_acc  = out_valid && out_ready;
    assign last_out = out_acc && (out_cnt == A_LAST);

    always_ff @(posedge clk) begin
        if (accept) mem[wa] <= in_data;
        if (issue)  rd_data <= mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            p         <= '0;
            b         <= '0;
            y         <= '0;
            xi        <= '0;
            wa        <= '0;
            blk_base  <= '0;
            part_base <= '0;
            ra        <= '0;
            out_cnt   <= '0;
            rd_all    <= 1'b0;
            rd_vld    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) state <= S_FILL;

            // Address walk uses only adders; all counters land back on 0 at frame end.
            if (accept) begin
                if (!xi_wrap) begin
                    xi <= xi + 1'b1;
                    wa <= wa + 1'b1;
                end else begin
                    xi <= '0;
                    if (!y_wrap) begin
                        y  <= y + 1'b1;
                        wa <= wa + (last_blk ? STEP_LAST : STEP_FULL);
                    end else begin
                        y <= '0;
                        if (!last_blk) begin
                            b        <= b + 1'b1;
                            blk_base <= blk_base + A_BLK;
                            wa       <= blk_base + A_BLK;
                        end else begin
                            b <= '0;
                            if (!p_wrap) begin
                                p         <= p + 1'b1;
                                part_base <= part_base + A_PART;
                                blk_base  <= part_base + A_PART;
                                wa        <= part_base + A_PART;
                            end else begin
                                p         <= '0;
                                part_base <= '0;
                                blk_base  <= '0;
                                wa        <= '0;
                                state     <= S_DRAIN;
                            end
                        end
                    end
                end
            end

            if (issue) begin
                if (ra == A_LAST) begin
                    ra     <= '0;
                    rd_all <= 1'b1;
                end else begin
                    ra <= ra + 1'b1;
                end
            end
            if (issue)     rd_vld <= 1'b1;
            else if (load) rd_vld <= 1'b0;

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= rd_data;
            end else if (out_acc) begin
                out_valid <= 1'b0;
            end

            if (out_acc) out_cnt <= out_cnt + 1'b1;
            if (last_out) begin
                out_cnt <= '0;
                rd_all  <= 1'b0;
                state   <= S_IDLE;
                done    <= 1'b1;
            end
        end
    end

`ifdef REORDER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        checksum <= '0;
        else if (state == S_IDLE && start) checksum <= '0;
        else if (out_acc)                  checksum <= checksum + 16'(out_data);
    end
`endif
endmodule
